lu_arbiter: RTL and testbench



---
 rtl/lu_arbiter_if.sv | 38 +++
 rtl/lu_arbiter.sv | 95 +++++++++
 tb/tb_lu_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/lu_arbiter_if.sv
// Request/response bundle between two clients, one consumer and lu_arbiter.
// master = client/consumer side, slave = arbiter side.
interface lu_arbiter_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [1:0]       req0_op;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [1:0]       req1_op;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic [CNT_W-1:0] op_count;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_data, op_count
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_data, op_count
   );
endinterface

// File: rtl/lu_arbiter.sv
// Round-robin arbiter sharing one per-bit AND/NAND/OR/NOR logic unit between two
// requesters; IDLE -> EXEC -> RESP sequencer with a registered valid/ready response.
module lu_arbiter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input logic         clk,
   input logic         rst_n,
   lu_arbiter_if.slave bus_io
);
   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e           state_q;
   logic             prio_q;
   logic             id_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [1:0]       op_q;
   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic [CNT_W-1:0] op_count_q;

   logic             idle;
   logic             any_req;
   logic             gnt1;
   logic [WIDTH-1:0] lu_res;

   // Requester 1 wins when alone or when both ask and priority points at it.
   always_comb begin
      idle              = (state_q == StIdle);
      any_req           = bus_io.req0_valid | bus_io.req1_valid;
      gnt1              = bus_io.req1_valid & (~bus_io.req0_valid | prio_q);
      bus_io.req0_ready = idle & bus_io.req0_valid & ~gnt1;
      bus_io.req1_ready = idle & gnt1;
   end

   // One logic-unit slice per bit: op_q[1] selects OR family, op_q[0] inverts.
   for (genvar i = 0; i < WIDTH; i++) begin : g_lu
      logic and_v;
      logic or_v;
      logic raw_v;
      assign and_v     = a_q[i] & b_q[i];
      assign or_v      = a_q[i] | b_q[i];
      assign raw_v     = op_q[1] ? or_v : and_v;
      assign lu_res[i] = raw_v ^ op_q[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         prio_q      <= 1'b0;
         id_q        <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         op_count_q  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (any_req) begin
                  id_q    <= gnt1;
                  a_q     <= gnt1 ? bus_io.req1_a  : bus_io.req0_a;
                  b_q     <= gnt1 ? bus_io.req1_b  : bus_io.req0_b;
                  op_q    <= gnt1 ? bus_io.req1_op : bus_io.req0_op;
                  state_q <= StExec;
               end
            end
            StExec: begin
               rsp_data_q  <= lu_res;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= StResp;
            end
            StResp: begin
               if (bus_io.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  op_count_q  <= op_count_q + 1'b1;
                  prio_q      <= ~rsp_id_q;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.rsp_valid = rsp_valid_q;
   assign bus_io.rsp_id    = rsp_id_q;
   assign bus_io.rsp_data  = rsp_data_q;
   assign bus_io.op_count  = op_count_q;
endmodule

// File: tb/tb_lu_arbiter.sv
// Self-checking bench for lu_arbiter: directed plan steps plus randomized transactions
// checked against a transaction-level reference model.
module tb_lu_arbiter;
   logic clk;
   logic rst_n;

   lu_arbiter_if #(.WIDTH(4), .CNT_W(8)) bus ();

   lu_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // Reference model state: favoured requester and completed-operation total.
   bit exp_prio  = 1'b0;
   int exp_count = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] lu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
      case (op)
         2'b00:   return a & b;
         2'b01:   return ~(a & b);
         2'b10:   return a | b;
         default: return ~(a | b);
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one transaction starting in IDLE at posedge+1; ends back in IDLE at posedge+1.
   task automatic do_txn(input bit v0, input bit v1,
                         input logic [3:0] a0, input logic [3:0] b0, input logic [1:0] op0,
                         input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] op1,
                         input logic [3:0] na, input logic [3:0] nb, input int stall);
      bit         w;
      logic [3:0] exp_data;
      bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
      bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
      #1;
      w        = (v0 && v1) ? exp_prio : v1;
      exp_data = w ? lu_ref(a1, b1, op1) : lu_ref(a0, b0, op0);
      check("grant_ready0", 32'(bus.req0_ready), 32'(v0 && !w));
      check("grant_ready1", 32'(bus.req1_ready), 32'(w));
      step();
      // EXEC: operands change and rsp_ready toggles; neither may matter.
      bus.req0_a = na; bus.req0_b = nb; bus.req1_a = na; bus.req1_b = nb;
      bus.rsp_ready = 1'($urandom_range(1));
      check("exec_valid", 32'(bus.rsp_valid), 32'd0);
      check("exec_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      step();
      check("resp_valid", 32'(bus.rsp_valid), 32'd1);
      check("resp_id", 32'(bus.rsp_id), 32'(w));
      check("resp_data", 32'(bus.rsp_data), 32'(exp_data));
      for (int i = 0; i < stall; i++) begin
         bus.rsp_ready = 1'b0;
         step();
         check("stall_valid", 32'(bus.rsp_valid), 32'd1);
         check("stall_id", 32'(bus.rsp_id), 32'(w));
         check("stall_data", 32'(bus.rsp_data), 32'(exp_data));
         check("stall_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      step();
      exp_count++;
      exp_prio = ~w;
      check("done_valid", 32'(bus.rsp_valid), 32'd0);
      check("done_count", 32'(bus.op_count), 32'(exp_count % 256));
      check("done_data_kept", 32'(bus.rsp_data), 32'(exp_data));
      check("done_id_kept", 32'(bus.rsp_id), 32'(w));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit         rv0;
      bit         rv1;
      int         r;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
      bus.rsp_ready  = 1'b0;
      rst_n = 1'b1;

      // Asynchronous reset before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      check("rst_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_count", 32'(bus.op_count), 32'd0);
      check("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      check("rst_data", 32'(bus.rsp_data), 32'd0);
      check("rst_id", 32'(bus.rsp_id), 32'd0);
      step();
      step();
      rst_n = 1'b1;

      // Idle with no requests; rsp_ready outside RESP is ignored.
      for (int i = 0; i < 3; i++) begin
         bus.rsp_ready = 1'(i);
         step();
         check("idle_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
         check("idle_valid", 32'(bus.rsp_valid), 32'd0);
         check("idle_count", 32'(bus.op_count), 32'd0);
      end

      // All four opcodes from requester 0.
      for (int op = 0; op < 4; op++)
         do_txn(1'b1, 1'b0, 4'b1100, 4'b1010, 2'(op), 4'h0, 4'h0, 2'b00, 4'h5, 4'h9, 0);
      check("opcodes_count", 32'(bus.op_count), 32'd4);

      // Contention: grants alternate as the model's priority flips.
      for (int i = 0; i < 4; i++)
         do_txn(1'b1, 1'b1, 4'hF, 4'h0, 2'b10, 4'hF, 4'hF, 2'b00, 4'h0, 4'h0, 0);

      // Backpressure for 5 cycles with both requesters waiting.
      do_txn(1'b1, 1'b1, 4'h6, 4'h3, 2'b01, 4'h9, 4'hC, 2'b11, 4'hA, 4'h5, 5);

      // Operand change during EXEC must not affect the in-flight result.
      do_txn(1'b0, 1'b1, 4'h0, 4'h0, 2'b00, 4'h3, 4'h5, 2'b00, 4'hF, 4'hF, 0);

      // Randomized mix, with occasional idle gaps where valid is withheld.
      for (int i = 0; i < 40; i++) begin
         r   = int'($urandom_range(3, 1));
         rv0 = r[0];
         rv1 = r[1];
         if ($urandom_range(3) == 0) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            step();
            check("gap_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
         end
         do_txn(rv0, rv1, 4'($urandom), 4'($urandom), 2'($urandom),
                4'($urandom), 4'($urandom), 2'($urandom),
                4'($urandom), 4'($urandom), int'($urandom_range(2)));
      end

      // Run past 256 completions so the counter wraps 255 -> 0.
      while (exp_count < 257)
         do_txn(1'b1, 1'b1, 4'($urandom), 4'($urandom), 2'($urandom),
                4'($urandom), 4'($urandom), 2'($urandom), 4'h0, 4'h0, 0);

      // Mid-operation reset: leave prio at 1, then abort a grant to requester 1.
      do_txn(1'b1, 1'b0, 4'h1, 4'h1, 2'b00, 4'h0, 4'h0, 2'b00, 4'h0, 4'h0, 0);
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      bus.rsp_ready  = 1'b0;
      #1;
      check("abort_grant1", 32'(bus.req1_ready), 32'd1);
      step();
      step();
      check("abort_resp_valid", 32'(bus.rsp_valid), 32'd1);
      #3;
      rst_n = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      #1;
      exp_count = 0;
      exp_prio  = 1'b0;
      check("midrst_valid", 32'(bus.rsp_valid), 32'd0);
      check("midrst_count", 32'(bus.op_count), 32'd0);
      check("midrst_data", 32'(bus.rsp_data), 32'd0);
      check("midrst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      step();
      rst_n = 1'b1;
      do_txn(1'b1, 1'b1, 4'hA, 4'h5, 2'b10, 4'h3, 4'h3, 2'b01, 4'h0, 4'h0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
